// File: rtl/gfx_rom_arbiter_if.sv
// Bus bundle between the 005885 fetch/download requesters, the shared
// graphics ROM store and the arbiter that sequences them.
interface gfx_rom_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 16
);
  logic          dl_req;
  logic [AW-1:0] dl_addr;
  logic [DW-1:0] dl_data;
  logic          dl_ack;

  logic          tile_req;
  logic [AW-1:0] tile_addr;
  logic [DW-1:0] tile_data;
  logic          tile_valid;

  logic          spr_req;
  logic [AW-1:0] spr_addr;
  logic [DW-1:0] spr_data;
  logic          spr_valid;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_rdy;

  logic          busy;
  logic          timeout_err;

  // Arbiter view: serves the requesters and drives the memory command side.
  modport slave (
    input  dl_req, dl_addr, dl_data,
    input  tile_req, tile_addr,
    input  spr_req, spr_addr,
    input  mem_rdata, mem_rdy,
    output dl_ack, tile_data, tile_valid, spr_data, spr_valid,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output busy, timeout_err
  );

  // Environment view: requesters plus the memory model.
  modport master (
    output dl_req, dl_addr, dl_data,
    output tile_req, tile_addr,
    output spr_req, spr_addr,
    output mem_rdata, mem_rdy,
    input  dl_ack, tile_data, tile_valid, spr_data, spr_valid,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  busy, timeout_err
  );
endinterface

// File: rtl/gfx_rom_arbiter.sv
// Shares one single-port graphics ROM between the download writer and the
// 005885 tile/sprite fetchers: download has absolute priority, tile/sprite alternate.
module gfx_rom_arbiter #(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int TIMEOUT = 64
) (
  input  logic             clk_49m,
  input  logic             reset,
  gfx_rom_arbiter_if.slave bus
);

  localparam int CW = 10;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;
  typedef enum logic [1:0] {G_DL, G_TILE, G_SPR} gnt_t;

  state_t        r_state;
  gnt_t          r_gnt;
  logic          r_last_spr;
  logic [CW-1:0] r_cnt;

  logic          r_mem_req;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic [DW-1:0] r_tile_data;
  logic [DW-1:0] r_spr_data;
  logic          r_dl_ack;
  logic          r_tile_valid;
  logic          r_spr_valid;
  logic          r_timeout_err;

  logic          w_pick_tile;
  logic          w_pick_spr;
  logic          w_timeout;

  // Tile wins a tie only when the sprite side was served last.
  assign w_pick_tile = bus.tile_req && (!bus.spr_req || r_last_spr);
  assign w_pick_spr  = bus.spr_req && !w_pick_tile;
  assign w_timeout   = (r_cnt == TO_LAST);

  always_ff @(posedge clk_49m) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_gnt         <= G_DL;
      r_last_spr    <= 1'b1;
      r_cnt         <= '0;
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_tile_data   <= '0;
      r_spr_data    <= '0;
      r_dl_ack      <= 1'b0;
      r_tile_valid  <= 1'b0;
      r_spr_valid   <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_mem_req    <= 1'b0;
      r_dl_ack     <= 1'b0;
      r_tile_valid <= 1'b0;
      r_spr_valid  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.dl_req) begin
            r_gnt       <= G_DL;
            r_mem_addr  <= bus.dl_addr;
            r_mem_wdata <= bus.dl_data;
            r_mem_we    <= 1'b1;
            r_mem_req   <= 1'b1;
            r_state     <= S_ISSUE;
          end else if (w_pick_tile) begin
            r_gnt      <= G_TILE;
            r_mem_addr <= bus.tile_addr;
            r_mem_we   <= 1'b0;
            r_mem_req  <= 1'b1;
            r_state    <= S_ISSUE;
          end else if (w_pick_spr) begin
            r_gnt      <= G_SPR;
            r_mem_addr <= bus.spr_addr;
            r_mem_we   <= 1'b0;
            r_mem_req  <= 1'b1;
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_cnt    <= '0;
          r_mem_we <= 1'b0;
          r_state  <= S_WAIT;
        end
        S_WAIT: begin
          // A response landing on the timeout cycle still counts as a real answer.
          if (bus.mem_rdy || w_timeout) begin
            r_state <= S_DONE;
            if (!bus.mem_rdy) r_timeout_err <= 1'b1;
            case (r_gnt)
              G_TILE: begin
                r_tile_data  <= bus.mem_rdy ? bus.mem_rdata : '1;
                r_tile_valid <= 1'b1;
              end
              G_SPR: begin
                r_spr_data  <= bus.mem_rdy ? bus.mem_rdata : '1;
                r_spr_valid <= 1'b1;
              end
              default: r_dl_ack <= 1'b1;
            endcase
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (r_gnt == G_TILE) r_last_spr <= 1'b0;
          else if (r_gnt == G_SPR) r_last_spr <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_req     = r_mem_req;
  assign bus.mem_we      = r_mem_we;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.mem_wdata   = r_mem_wdata;
  assign bus.tile_data   = r_tile_data;
  assign bus.spr_data    = r_spr_data;
  assign bus.dl_ack      = r_dl_ack;
  assign bus.tile_valid  = r_tile_valid;
  assign bus.spr_valid   = r_spr_valid;
  assign bus.timeout_err = r_timeout_err;
  assign bus.busy        = (r_state != S_IDLE);

endmodule

// File: doc/gfx_rom_arbiter.md
Name: gfx_rom_arbiter

Overview:
- Sequences one shared single-port graphics ROM store between three requesters: ROM download writer, 005885 tilemap fetch and 005885 sprite fetch.
- Replaces per-requester dual-port ROM copies. Lets sprite fetches read tilemap ROM space without a second port.
- Sits between the 005885 R/S fetch buses and the graphics ROM memory, which has variable read/write latency signalled by a ready pulse.

Parameters:
- AW, 16, address width for all requesters and memory.
- DW, 16, data width (tile/sprite words; download data zero-extended by the caller).
- TIMEOUT, 64, maximum cycles spent in WAIT before forced completion (must be 2..1023).

Ports:
- clk_49m  in  1  system clock (49.152 MHz)
- reset  in  1  synchronous, active-high reset
- dl_req  in  1  download write request, held until dl_ack
- dl_addr  in  AW  download address
- dl_data  in  DW  download write data
- dl_ack  out  1  one-cycle completion pulse for download write
- tile_req  in  1  tile fetch request, held until tile_valid
- tile_addr  in  AW  tile fetch address
- tile_data  out  DW  tile read data, held until next tile completion
- tile_valid  out  1  one-cycle tile completion pulse
- spr_req  in  1  sprite fetch request, held until spr_valid
- spr_addr  in  AW  sprite fetch address
- spr_data  out  DW  sprite read data, held until next sprite completion
- spr_valid  out  1  one-cycle sprite completion pulse
- mem_req  out  1  one-cycle memory command strobe
- mem_we  out  1  write qualifier, valid with mem_req
- mem_addr  out  AW  registered command address, held from ISSUE through WAIT
- mem_wdata  out  DW  registered write data, held from ISSUE through WAIT
- mem_rdata  in  DW  memory read data, valid when mem_rdy=1
- mem_rdy  in  1  memory completion pulse
- busy  out  1  high in any state other than IDLE
- timeout_err  out  1  sticky; set on any forced completion

Behaviour:
- Reset values: all outputs 0, tile_data/spr_data 0, state IDLE, round-robin pointer = "sprite last served" (tile wins first tie), timeout counter 0.
- States are IDLE, ISSUE, WAIT, DONE.
- IDLE: request inputs are sampled at the clock edge.
  - Priority: dl_req is absolute; otherwise tile_req vs spr_req by round-robin.
  - Only one requester active: it wins regardless of the pointer.
  - On grant: latch grant id, address and (download only) data into mem_addr/mem_wdata, go to ISSUE.
  - No request: stay in IDLE.
- ISSUE: exactly one cycle. mem_req=1; mem_we=1 only for a download grant. Clear the timeout counter, go to WAIT.
  - mem_rdy during ISSUE is ignored; memory must answer no earlier than the cycle after mem_req.
- WAIT, normal completion: mem_rdy=1 moves to DONE.
  - Tile or sprite grant: latch mem_rdata into that requester's data register.
  - Download grant: read data is discarded.
- WAIT, timeout: counter increments each WAIT cycle. If it reaches TIMEOUT-1 without mem_rdy, go to DONE anyway.
  - Read grant: data register = all ones.
  - timeout_err set and stays set until reset.
  - mem_rdy arriving in the same cycle as the timeout counts as normal completion.
- DONE: exactly one cycle. Exactly one of dl_ack/tile_valid/spr_valid is high, matching the grant.
  - If the grant was tile or sprite, the pointer records it as last served. Download grants leave the pointer unchanged.
  - No new grant is made in DONE. Go to IDLE.
- Requester rule: deassert req by the edge ending the cycle after the completion pulse. A req still high in IDLE is a new request.
- Latency: request sampled at edge 0 → ISSUE cycle 1 → WAIT from cycle 2 → DONE (pulse) the cycle after mem_rdy. Minimum 4 cycles from request to pulse.
- A request change (address or drop) after grant has no effect on the transaction in flight. A dropped req still gets its completion pulse.
- mem_addr/mem_wdata change only on grant. mem_rdy outside WAIT is ignored (covers stale responses after reset).
- Reset mid-operation: return to IDLE immediately with reset values. The in-flight transaction is abandoned and no completion pulse is issued.

Test Plan:
- Single tile read: tile_req=1, tile_addr=0x1234; memory answers mem_rdy 3 cycles after mem_req with 0xBEEF → mem_req pulse with mem_addr=0x1234, mem_we=0; tile_valid one cycle; tile_data=0xBEEF held; spr_data stays 0.
- Download priority: dl_req (addr 0x0040, data 0x00A5), tile_req and spr_req all asserted in the same cycle → download first (mem_we=1, mem_wdata=0x00A5, dl_ack); then tile; then sprite. Each transaction is separated by the DONE/IDLE cycles.
- Round-robin fairness: tile_req and spr_req held continuously for 6 transactions, memory 1-cycle ready → grants strictly alternate tile, sprite, tile, sprite, ...; no starvation.
- Timeout: TIMEOUT=8, sprite read, mem_rdy never asserted → spr_valid at the 8th WAIT cycle boundary; spr_data=0xFFFF; timeout_err=1 and still 1 after 100 further normal transactions.
- Reset mid-WAIT: tile grant in WAIT, reset pulsed 1 cycle, then mem_rdy arrives → no tile_valid; tile_data=0; busy=0; next request served normally with tile winning the first tie.
- Boundary: mem_rdy asserted during ISSUE and again in WAIT with 0x5A5A → only the WAIT response is captured; tile_data=0x5A5A.
